coreapb3_iaddr_bank: RTL and testbench

// - Multi-channel indirect address register bank on a CoreAPB3 slot; successor to the single-register indirect address block.
// - Holds NUM_CH 32-bit indirect addresses, each loaded over 8/16/32-bit APB.
// - Narrow-bus writes go to a shadow register; the address commits atomically, so downstream logic never sees a torn address.
// - Optional hardware auto-increment per channel after each indirect transfer.

---
 rtl/coreapb3_iaddr_bank.sv | 123 ++++++++++++
 tb/tb_coreapb3_iaddr_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/coreapb3_iaddr_bank.sv
// coreapb3_iaddr_bank: multi-channel indirect address register bank with atomic shadow commit on a CoreAPB3 slot.
// Optional feature macro IADDR_AUTOINC_EN: per-channel hardware auto-increment by a writable CTRL.STEP.
module coreapb3_iaddr_bank #(
    parameter int APB_DWIDTH = 32,
    parameter int MADDR_BITS = 32,
    parameter int NUM_CH     = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [31:0]           PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [NUM_CH-1:0]     IADDR_INC,
    output logic [32*NUM_CH-1:0]  IADDR_REG,
    output logic [NUM_CH-1:0]     IADDR_UPD
);
    localparam int          L         = 32 / APB_DWIDTH;
    localparam logic [2:0]  TOP_K     = 3'(L - 1);
    localparam int          TOP_SH    = APB_DWIDTH * (L - 1);
    localparam logic [31:0] LANE_MASK = 32'((64'd1 << APB_DWIDTH) - 64'd1);

    logic          w_valid, w_ch_ok, w_acc, w_wr;
    logic          w_is_lane, w_is_ctrl, w_is_stat, w_lane_ok;
    logic [2:0]    w_ch, w_k;
    logic [6:0]    w_sh;
    logic [31:0]   w_lane_in;
    logic [NUM_CH-1:0]   w_dirty;
    logic [8*NUM_CH-1:0] w_step;
    logic [255:0]  w_iaddr_pad;
    logic [7:0]    w_dirty_pad;
    logic [63:0]   w_step_pad;
    logic [31:0]   w_word, w_rd_lane;

    assign w_valid   = PADDR[MADDR_BITS-5:8] == '0;
    assign w_ch      = PADDR[7:5];
    assign w_k       = {1'b0, PADDR[3:2]};
    assign w_ch_ok   = {1'b0, w_ch} < 4'(NUM_CH);
    assign w_is_lane = ~PADDR[4];
    assign w_is_ctrl = PADDR[4:2] == 3'b100;
    assign w_is_stat = PADDR[4:2] == 3'b101;
    assign w_lane_ok = w_k <= TOP_K;
    assign w_acc     = PSEL & PENABLE & w_valid;
    assign w_wr      = w_acc & PWRITE & w_ch_ok;
    assign w_sh      = 7'(APB_DWIDTH) * {4'b0, w_k};
    assign w_lane_in = PWDATA & LANE_MASK;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [31:0] r_iaddr, r_shadow;
        logic        r_dirty, r_upd;
        logic [7:0]  w_step_c;
        logic        w_sel, w_lo, w_top;

        assign w_sel = w_wr & (w_ch == 3'(c));
        assign w_lo  = w_sel & w_is_lane & (w_k < TOP_K);
        assign w_top = w_sel & w_is_lane & (w_k == TOP_K);

`ifdef IADDR_AUTOINC_EN
        logic [7:0] r_step;
        // CTRL.STEP: loaded from lane 0 of an APB write to the channel's CTRL offset.
        always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET)
                r_step <= 8'd4;
            else if (w_sel & w_is_ctrl)
                r_step <= PWDATA[7:0];
        end
        assign w_step_c = r_step;
`else
        assign w_step_c = 8'd0;
`endif

        // Lower lanes collect in the shadow; the top lane commits shadow plus new lane in one edge.
        always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET) begin
                r_iaddr  <= '0;
                r_shadow <= '0;
                r_dirty  <= 1'b0;
                r_upd    <= 1'b0;
            end else begin
                r_upd <= w_top;
                if (w_lo) begin
                    r_shadow <= (r_shadow & ~(LANE_MASK << w_sh)) | (w_lane_in << w_sh);
                    r_dirty  <= 1'b1;
                end
                if (w_top) begin
                    r_iaddr <= (r_shadow & ~(LANE_MASK << TOP_SH)) | (w_lane_in << TOP_SH);
                    r_dirty <= 1'b0;
                end
`ifdef IADDR_AUTOINC_EN
                else if (IADDR_INC[c])
                    r_iaddr <= r_iaddr + {24'b0, r_step};
`endif
            end
        end

        assign IADDR_REG[32*c +: 32] = r_iaddr;
        assign IADDR_UPD[c]          = r_upd;
        assign w_dirty[c]            = r_dirty;
        assign w_step[8*c +: 8]      = w_step_c;
    end

    assign w_iaddr_pad = 256'(IADDR_REG);
    assign w_dirty_pad = 8'(w_dirty);
    assign w_step_pad  = 64'(w_step);

    // Read mux: committed address lane, CTRL or STATUS of the addressed channel; zero otherwise.
    always_comb begin
        w_word    = w_iaddr_pad[32*w_ch +: 32];
        w_rd_lane = (w_word >> w_sh) & LANE_MASK;
        PRDATA    = '0;
        if (PSEL & w_valid & w_ch_ok)
            PRDATA = w_is_lane ? (w_lane_ok ? w_rd_lane : 32'd0) :
                     w_is_ctrl ? {24'b0, w_step_pad[8*w_ch +: 8]} :
                     w_is_stat ? {31'b0, w_dirty_pad[w_ch]} : 32'd0;
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = w_acc & ~w_ch_ok;
endmodule

// File: tb/tb_coreapb3_iaddr_bank.sv
// tb_coreapb3_iaddr_bank: directed table and sequences over 32/8/16-bit instances of the indirect address bank.
module tb_coreapb3_iaddr_bank;
`ifdef IADDR_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  psel = '0, rdy, err;
    logic        penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, rd32, rd8, rd16, rd;
    logic [1:0]  inc = '0, upd32, upd8, upd16;
    logic [63:0] ia32, ia8, ia16;
    logic        er;
    int          n_pass = 0, n_tot = 0;
    vec_t        tv[$];

    always #5 clk = ~clk;

    coreapb3_iaddr_bank #(.APB_DWIDTH(32), .MADDR_BITS(32), .NUM_CH(2)) u32 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(rd32), .PREADY(rdy[0]), .PSLVERR(err[0]),
        .IADDR_INC(inc), .IADDR_REG(ia32), .IADDR_UPD(upd32));
    coreapb3_iaddr_bank #(.APB_DWIDTH(8), .MADDR_BITS(32), .NUM_CH(2)) u8 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(rd8), .PREADY(rdy[1]), .PSLVERR(err[1]),
        .IADDR_INC(2'b00), .IADDR_REG(ia8), .IADDR_UPD(upd8));
    coreapb3_iaddr_bank #(.APB_DWIDTH(16), .MADDR_BITS(32), .NUM_CH(2)) u16 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(rd16), .PREADY(rdy[2]), .PSLVERR(err[2]),
        .IADDR_INC(2'b00), .IADDR_REG(ia16), .IADDR_UPD(upd16));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apb(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] r, output logic e);
        @(negedge clk);
        psel = 3'(1 << d); pwrite = wr; paddr = a; pwdata = wd; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        r = (d == 0) ? rd32 : (d == 1) ? rd8 : rd16;
        e = err[d];
        @(negedge clk);
        psel = '0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic vw(input int d, input logic [31:0] a, input logic [31:0] wd, input logic ee);
        tv.push_back('{d, 1'b1, a, wd, 32'h0, ee});
    endtask

    task automatic vr(input int d, input logic [31:0] a, input logic [31:0] x, input logic ee);
        tv.push_back('{d, 1'b0, a, 32'h0, x, ee});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vr(0, 32'h00, 32'h12345678, 0);  vr(0, 32'h04, 32'h0, 0);
        vw(0, 32'h04, 32'hDEAD, 0);      vr(0, 32'h00, 32'h12345678, 0);
        vr(0, 32'h04, 32'h0, 0);         vw(0, 32'h20, 32'hCAFEF00D, 0);
        vr(0, 32'h20, 32'hCAFEF00D, 0);  vr(0, 32'h00, 32'h12345678, 0);
        vr(0, 32'h14, 32'h0, 0);         vr(0, 32'h18, 32'h0, 0);
        vw(0, 32'h40, 32'h55, 1);        vr(0, 32'h40, 32'h0, 1);
        vw(0, 32'h100, 32'hFFFF, 0);     vr(0, 32'h00, 32'h12345678, 0);
        vw(0, 32'h10, 32'h8, 0);         vr(0, 32'h10, AI ? 32'h8 : 32'h0, 0);
        vr(1, 32'h34, 32'h0, 0);         vr(1, 32'h20, 32'h78, 0);
        vr(1, 32'h24, 32'h56, 0);        vr(1, 32'h28, 32'h34, 0);
        vr(1, 32'h2C, 32'h12, 0);
        vw(1, 32'h00, 32'hAA, 0);        vw(1, 32'h00, 32'hBB, 0);
        vw(1, 32'h04, 32'h11, 0);        vr(1, 32'h14, 32'h1, 0);
        vr(1, 32'h00, 32'h0, 0);         vw(1, 32'h0C, 32'h44, 0);
        vr(1, 32'h14, 32'h0, 0);         vr(1, 32'h00, 32'hBB, 0);
        vr(1, 32'h04, 32'h11, 0);        vr(1, 32'h08, 32'h0, 0);
        vr(1, 32'h0C, 32'h44, 0);
        vw(1, 32'h20, 32'h99, 0);        vw(1, 32'h34, 32'h0, 0);
        vr(1, 32'h34, 32'h1, 0);         vw(1, 32'h24, 32'hAB, 0);
        vw(1, 32'h28, 32'hCD, 0);        vw(1, 32'h2C, 32'hEF, 0);
        vr(1, 32'h34, 32'h0, 0);         vr(1, 32'h20, 32'h99, 0);
        vr(1, 32'h24, 32'hAB, 0);        vr(1, 32'h28, 32'hCD, 0);
        vr(1, 32'h2C, 32'hEF, 0);        vr(1, 32'h60, 32'h0, 1);
        vr(1, 32'h120, 32'h0, 0);        vr(1, 32'h10, AI ? 32'h4 : 32'h0, 0);
        vw(2, 32'h00, 32'hBEEF, 0);      vr(2, 32'h14, 32'h1, 0);
        vr(2, 32'h00, 32'h0, 0);         vr(2, 32'h04, 32'h0, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ia32", ia32, 64'h0);
        chk("rst_ia8", ia8, 64'h0);
        chk("rst_ia16", ia16, 64'h0);
        chk("rst_upd", {upd32, upd8, upd16}, 64'h0);
        chk("pready", 64'(rdy), 64'h7);

        apb(0, 1, 32'h00, 32'h12345678, rd, er);
        #1;
        chk("c32_upd_pulse", 64'(upd32), 64'h1);
        chk("c32_reg", 64'(ia32[31:0]), 64'h12345678);
        @(negedge clk); #1;
        chk("c32_upd_clear", 64'(upd32), 64'h0);

        apb(1, 1, 32'h20, 32'h78, rd, er);
        apb(1, 1, 32'h24, 32'h56, rd, er);
        apb(1, 1, 32'h28, 32'h34, rd, er);
        #1;
        chk("n8_no_tear", 64'(ia8[63:32]), 64'h0);
        chk("n8_no_upd", 64'(upd8), 64'h0);
        apb(1, 0, 32'h34, 32'h0, rd, er);
        chk("n8_dirty", 64'(rd), 64'h1);
        apb(1, 1, 32'h2C, 32'h12, rd, er);
        #1;
        chk("n8_commit", 64'(ia8[63:32]), 64'h12345678);
        chk("n8_upd", 64'(upd8), 64'h2);

        apb(0, 1, 32'h20, 32'hFFFFFFFC, rd, er);
        inc = 2'b10;
        @(negedge clk);
        inc = 2'b00;
        #1;
        chk("inc_wrap", 64'(ia32[63:32]), AI ? 64'h0 : 64'hFFFFFFFC);
        inc = 2'b10;
        apb(0, 1, 32'h20, 32'h100, rd, er);
        inc = 2'b00;
        #1;
        chk("inc_vs_commit", 64'(ia32[63:32]), 64'h100);
        chk("inc_other_ch", 64'(ia32[31:0]), 64'h12345678);

        foreach (tv[i]) begin
            apb(tv[i].d, tv[i].wr, tv[i].a, tv[i].wd, rd, er);
            chk($sformatf("v%0d_err", i), 64'(er), 64'(tv[i].ee));
            if (!tv[i].wr) chk($sformatf("v%0d_rd", i), 64'(rd), 64'(tv[i].er));
        end

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_ia32", ia32, 64'h0);
        chk("arst_ia8", ia8, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        apb(2, 0, 32'h14, 32'h0, rd, er);
        chk("arst_dirty", 64'(rd), 64'h0);
        apb(2, 1, 32'h04, 32'h1234, rd, er);
        #1;
        chk("arst_commit", 64'(ia16[31:0]), 64'h12340000);
        chk("arst_upd", 64'(upd16), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
